// File: rtl/lifo_arbiter_pkg.sv
// Shared types and constants for the LIFO arbiter slice: FSM encoding,
// operation codes, default geometry and a saturating counter helper.
package lifo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_BITWIDTH = 5;
  localparam int DEF_DEPTH    = 4;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/lifo_arbiter_if.sv
// Requester and stack-side signal bundle of the LIFO arbiter.
// slave = arbiter view, master = requesters plus attached stack.
interface lifo_arbiter_if
  import lifo_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int BITWIDTH = DEF_BITWIDTH
) ();

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_op;
  logic [NUM_REQ*BITWIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ-1:0]          rsp_valid;
  logic                        rsp_err;
  logic [BITWIDTH-1:0]         rsp_data;
  logic                        lifo_wEn;
  logic                        lifo_rEn;
  logic [BITWIDTH-1:0]         lifo_dIn;
  logic                        lifo_full;
  logic                        lifo_empty;
  logic [BITWIDTH-1:0]         lifo_dOut;

  modport slave (
    input  req_valid, req_op, req_data, lifo_full, lifo_empty, lifo_dOut,
    output req_ready, rsp_valid, rsp_err, rsp_data, lifo_wEn, lifo_rEn, lifo_dIn
  );

  modport master (
    output req_valid, req_op, req_data, lifo_full, lifo_empty, lifo_dOut,
    input  req_ready, rsp_valid, rsp_err, rsp_data, lifo_wEn, lifo_rEn, lifo_dIn
  );

endinterface

// File: rtl/lifo_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first requester at or above rr_ptr,
// wrapping past NUM_REQ-1 back to 0, wins.
module rr_arbiter #(
  parameter int  NUM_REQ = 4,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   winner,
  output logic               any_grant
);

  // Scan in priority order; the wrap is explicit so non-power-of-two counts work.
  always_comb begin
    int               raw_v;
    logic [PTR_W-1:0] sel_v;
    logic             hit_v;
    grant     = '0;
    winner    = '0;
    any_grant = 1'b0;
    raw_v     = 0;
    sel_v     = '0;
    hit_v     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      raw_v         = int'(rr_ptr) + i;
      sel_v         = (raw_v >= NUM_REQ) ? PTR_W'(raw_v - NUM_REQ) : PTR_W'(raw_v);
      hit_v         = !any_grant && req[sel_v];
      grant[sel_v]  = grant[sel_v] | hit_v;
      winner        = hit_v ? sel_v : winner;
      any_grant     = any_grant | hit_v;
    end
  end

endmodule

// File: rtl/lifo_arbiter.sv
// Round-robin arbiter sharing one LIFO stack between NUM_REQ requesters.
// Optional macro LIFO_ARBITER_STATS_EN adds saturating ovf_cnt/unf_cnt outputs.
module lifo_arbiter
  import lifo_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int BITWIDTH = DEF_BITWIDTH,
  parameter int DEPTH    = DEF_DEPTH
) (
  input logic           clk,
  input logic           rst,
  lifo_arbiter_if.slave bus
`ifdef LIFO_ARBITER_STATS_EN
  ,
  output logic [7:0]    ovf_cnt,
  output logic [7:0]    unf_cnt
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16 || DEPTH < 1) begin : g_cfg_check
    $error("lifo_arbiter: unsupported NUM_REQ/DEPTH configuration");
  end

  state_e               state_r;
  state_e               next_state_s;
  logic [PTR_W-1:0]     rr_ptr_r;
  logic [PTR_W-1:0]     next_ptr_s;
  logic [PTR_W-1:0]     winner_r;
  logic [PTR_W-1:0]     arb_winner_s;
  logic [NUM_REQ-1:0]   arb_grant_s;
  logic [NUM_REQ-1:0]   rsp_valid_r;
  logic                 arb_any_s;
  logic                 capture_s;
  logic                 grant_op_s;
  logic                 op_r;
  logic                 err_r;
  logic [BITWIDTH-1:0]  grant_data_s;
  logic [BITWIDTH-1:0]  data_r;
  logic [BITWIDTH-1:0]  rsp_data_r;
  logic                 in_exec_s;
  logic                 push_ok_s;
  logic                 pop_ok_s;
  logic                 exec_err_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req       (bus.req_valid),
    .rr_ptr    (rr_ptr_r),
    .grant     (arb_grant_s),
    .winner    (arb_winner_s),
    .any_grant (arb_any_s)
  );

  // Winner's operands and the EXEC-cycle stack decision; rst suppresses strobes
  // so an operation caught by reset never touches the stack.
  always_comb begin
    grant_data_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_data_s = (arb_winner_s == PTR_W'(i)) ? bus.req_data[i*BITWIDTH +: BITWIDTH]
                                                 : grant_data_s;
    end
    grant_op_s = bus.req_op[arb_winner_s];
    next_ptr_s = (arb_winner_s == PTR_W'(NUM_REQ - 1)) ? '0 : arb_winner_s + PTR_W'(1);
    capture_s  = (state_r == IDLE) && arb_any_s && !rst;
    in_exec_s  = (state_r == EXEC) && !rst;
    push_ok_s  = in_exec_s && (op_r == OP_PUSH) && !bus.lifo_full;
    pop_ok_s   = in_exec_s && (op_r == OP_POP) && !bus.lifo_empty;
    exec_err_s = in_exec_s && !push_ok_s && !pop_ok_s;
  end

  // Next-state logic and the zero-latency grant pulse.
  always_comb begin
    next_state_s  = state_r;
    bus.req_ready = '0;
    case (state_r)
      IDLE: begin
        if (capture_s) begin
          next_state_s  = EXEC;
          bus.req_ready = arb_grant_s;
        end else begin
          next_state_s  = IDLE;
        end
      end
      EXEC:    next_state_s = RESP;
      RESP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State, round-robin pointer and captured request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      rr_ptr_r <= '0;
      winner_r <= '0;
      op_r     <= OP_POP;
      data_r   <= '0;
    end else begin
      state_r <= next_state_s;
      if (capture_s) begin
        winner_r <= arb_winner_s;
        op_r     <= grant_op_s;
        data_r   <= grant_data_s;
        rr_ptr_r <= next_ptr_s;
      end
    end
  end

  // Response registers: loaded at the end of EXEC so they are stable during RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_r <= '0;
      err_r       <= 1'b0;
      rsp_data_r  <= '0;
    end else if (state_r == EXEC) begin
      rsp_valid_r <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_r;
      err_r       <= exec_err_s;
      rsp_data_r  <= pop_ok_s ? bus.lifo_dOut : '0;
    end else begin
      rsp_valid_r <= '0;
    end
  end

  assign bus.lifo_wEn  = push_ok_s;
  assign bus.lifo_rEn  = pop_ok_s;
  assign bus.lifo_dIn  = push_ok_s ? data_r : '0;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_err   = err_r;
  assign bus.rsp_data  = rsp_data_r;

`ifdef LIFO_ARBITER_STATS_EN
  logic [7:0] ovf_r;
  logic [7:0] unf_r;

  // Saturating push-on-full / pop-on-empty counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 8'd0;
      unf_r <= 8'd0;
    end else begin
      if (exec_err_s && (op_r == OP_PUSH)) begin
        ovf_r <= sat_inc8(ovf_r);
      end
      if (exec_err_s && (op_r == OP_POP)) begin
        unf_r <= sat_inc8(unf_r);
      end
    end
  end

  assign ovf_cnt = ovf_r;
  assign unf_cnt = unf_r;
`else
  // Default build carries no error statistics.
`endif

endmodule

// File: doc/lifo_arbiter.md
Name: lifo_arbiter

Overview:
- Shares one LIFO stack (BITWIDTH-wide entries, 2**DEPTH deep, combinational top-of-stack read) between NUM_REQ requesters.
- Round-robin arbitration grants one push or pop request at a time.
- Drives the stack's write-enable, read-enable and data-in strobes.
- Returns a per-requester response carrying pop data and an error flag for push-on-full or pop-on-empty.

Parameters:
- NUM_REQ, 4: number of requesters, 2..16.
- BITWIDTH, 5: stack entry width.
- DEPTH, 4: log2 of stack capacity; must match the attached stack.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  request pending, one bit per requester; held until granted.
- req_op  in  NUM_REQ  per requester: 1 = push, 0 = pop.
- req_data  in  NUM_REQ*BITWIDTH  push data; requester i occupies bits [i*BITWIDTH +: BITWIDTH].
- req_ready  out  NUM_REQ  one-hot grant pulse; the request is consumed in this cycle.
- rsp_valid  out  NUM_REQ  one-hot response pulse to the granted requester.
- rsp_err  out  1  qualified by any rsp_valid; 1 = push on full or pop on empty, stack untouched.
- rsp_data  out  BITWIDTH  popped value; 0 for push or error.
- lifo_wEn  out  1  stack push strobe.
- lifo_rEn  out  1  stack pop strobe.
- lifo_dIn  out  BITWIDTH  stack push data.
- lifo_full  in  1  stack full flag.
- lifo_empty  in  1  stack empty flag.
- lifo_dOut  in  BITWIDTH  stack top-of-stack value, combinational.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is set, choose the winner by round-robin starting at rr_ptr.
  - Assert req_ready[winner] combinationally.
  - Register winner, op and data; next state EXEC.
  - rr_ptr <= (winner+1) mod NUM_REQ.
  - With no request, hold state and rr_ptr.
- EXEC, exactly one cycle:
  - Push: if lifo_full=0, assert lifo_wEn and drive lifo_dIn = registered data; otherwise set err.
  - Pop: if lifo_empty=0, assert lifo_rEn; register rsp_data <= lifo_dOut in the same cycle (value sampled before the pointer moves); otherwise set err.
  - Next state RESP.
- RESP, one cycle:
  - rsp_valid[winner]=1; rsp_err and rsp_data are registered values.
  - Next state IDLE.
  - A new arbitration may occur in the following IDLE cycle.
- Latency: request to grant is 0 cycles when the FSM is in IDLE; grant to response is 2 cycles. Throughput is one operation per 3 cycles.
- lifo_wEn and lifo_rEn are never asserted together and never asserted outside EXEC.
- Full/empty flags are sampled only in EXEC, so the flags reflect all prior operations.
- Reset values (same clock edge when rst=1, including mid-operation):
  - state=IDLE, rr_ptr=0.
  - All strobes, req_ready and rsp_valid = 0.
  - rsp_err=0, rsp_data=0.
- An operation in flight at reset is dropped with no response.
- Simultaneous requests: lowest index at or above rr_ptr wins, wrapping around.
- req_data of non-granted requesters is ignored.
- NUM_REQ width rules: winner index is $clog2(NUM_REQ) bits; rr_ptr wraps explicitly, not by overflow.

Optional Feature:
- Macro: LIFO_ARBITER_STATS_EN.
- When defined, add outputs ovf_cnt[7:0] and unf_cnt[7:0]:
  - Saturating counters of push-on-full and pop-on-empty errors.
  - Increment in EXEC; cleared by rst.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package lifo_pkg:
  - FSM state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2).
  - OP_PUSH=1'b1, OP_POP=1'b0.
  - Default BITWIDTH/DEPTH constants.
- One sub-module: rr_arbiter.
  - Combinational, parameter NUM_REQ.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, winner index, any_grant.

Test Plan:
1. Reset mid-EXEC: push granted, assert rst in the EXEC cycle -> next cycle lifo_wEn=0, rsp_valid=0, state IDLE, rr_ptr=0.
2. Single requester 0:
   - Push 5'h0A then 5'h15, then pop twice.
   - Expected: rsp_data 5'h15 then 5'h0A; rsp_err=0.
   - Each response arrives 2 cycles after its req_ready.
3. Round-robin: all four requesters valid continuously with pushes -> grant order 0,1,2,3,0, each grant 3 cycles apart.
4. Overflow:
   - Fill 16 entries, then a 17th push.
   - Expected: rsp_err=1, lifo_wEn never asserted for it, stack contents unchanged.
   - With LIFO_ARBITER_STATS_EN defined: ovf_cnt=1.
5. Underflow: pop from an empty stack after reset -> rsp_err=1, rsp_data=0, lifo_rEn=0; with the macro, unf_cnt=1.
6. Mixed contention:
   - Requester 2 pushes 5'h07 while requester 3 pops, rr_ptr=2.
   - Expected: requester 2 is granted first; requester 3 then receives 5'h07 with rsp_err=0.
